pr_write_buffer: RTL

Write-side counterpart of the PageRank read buffer. Accepts a stream of narrow WIDTH-bit elements, such as updated rank values, and packs them into one FULL_WIDTH-bit memory line. It issues the line as a single wide write with a per-element mask once the line is full or a flush is requested. It sits between the rank-update datapath and the memory write port, and uses the same lane ordering the read buffer unpacks.

---
 rtl/pr_pkg.sv | 22 ++
 rtl/pr_write_buffer.sv | 95 +++++++++
 2 files changed

// File: rtl/pr_pkg.sv
// Shared PageRank buffer definitions: line geometry, write-buffer states, lane ordering.
package pr_pkg;

  localparam int FULL_WIDTH_DEF = 512;
  localparam int WIDTH_DEF      = 64;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } wb_state_e;

  function automatic int max_elems(input int full_w, input int w);
    return full_w / w;
  endfunction

  // Slot 0 is the most-significant lane; the read buffer unpacks in the same order.
  function automatic int slot_to_lane(input int k, input int n);
    return n - 1 - k;
  endfunction

endpackage

// File: rtl/pr_write_buffer.sv
// Packs narrow elements into one masked wide memory write, issued when the line fills
// or on flush.
module pr_write_buffer
  import pr_pkg::*;
#(
  parameter int FULL_WIDTH = FULL_WIDTH_DEF,
  parameter int WIDTH      = WIDTH_DEF
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    idata_valid,
  input  logic [WIDTH-1:0]                        idata,
  input  logic [7:0]                              base,
  output logic                                    iready,
  input  logic                                    flush,
  output logic                                    flush_done,
  output logic                                    wvalid,
  input  logic                                    wready,
  output logic [FULL_WIDTH-1:0]                   wdata,
  output logic [max_elems(FULL_WIDTH, WIDTH)-1:0] wmask
);

  localparam int MAX_ELEMS = max_elems(FULL_WIDTH, WIDTH);
  localparam int LW        = (MAX_ELEMS > 1) ? $clog2(MAX_ELEMS) : 1;
  localparam logic [7:0] MAX_B     = 8'(MAX_ELEMS);
  localparam logic [3:0] LAST_SLOT = 4'(MAX_ELEMS - 1);

  wb_state_e                         state;
  logic [3:0]                        wrptr;
  logic                              flush_pend;
  logic [MAX_ELEMS-1:0][WIDTH-1:0]   lanes;
  logic [MAX_ELEMS-1:0]              mask;

  logic          accept;
  logic [3:0]    wr_slot;
  logic [LW-1:0] wr_lane;
  logic          go_drain;

  always_comb begin
    accept  = idata_valid && (state != DRAIN);
    wr_slot = wrptr;
    if (state == EMPTY) wr_slot = (base < MAX_B) ? base[3:0] : 4'd0;
    wr_lane = LW'(slot_to_lane(int'(wr_slot), MAX_ELEMS));
    // A flush only drains when something is (or is about to be) held.
    go_drain = (accept && (wr_slot == LAST_SLOT)) ||
               (flush && ((state == FILL) || (state == EMPTY && accept)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      wrptr      <= 4'd0;
      flush_pend <= 1'b0;
      flush_done <= 1'b0;
      lanes      <= '0;
      mask       <= '0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        EMPTY, FILL: begin
          if (accept) begin
            lanes[wr_lane] <= idata;
            mask[wr_lane]  <= 1'b1;
            wrptr          <= wr_slot + 4'd1;
          end
          if (go_drain) begin
            state      <= DRAIN;
            flush_pend <= flush;
          end else if (accept) begin
            state <= FILL;
          end
          if (state == EMPTY && flush && !accept) flush_done <= 1'b1;
        end
        DRAIN: begin
          if (flush) flush_pend <= 1'b1;
          if (wready) begin
            state      <= EMPTY;
            wrptr      <= 4'd0;
            lanes      <= '0;
            mask       <= '0;
            flush_pend <= 1'b0;
            flush_done <= flush_pend || flush;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign iready = (state != DRAIN);
  assign wvalid = (state == DRAIN);
  assign wdata  = lanes;
  assign wmask  = mask;

endmodule
